spi_ram_master: RTL and testbench
=================================

# spi_ram_master

Master-side controller for the SPI slave + synchronous RAM block. Accepts word-level read/write requests from two requesters, arbitrates between them round-robin, and sequences each request into the slave's 10-bit command frames (`00` write-address, `01` write-data, `10` read-address, `11` read-data) on `ss_n`/`mosi`. For reads it captures the 8-bit reply on `miso`. The slave shares `clk` with this block, and every SPI bit occupies exactly one `clk` cycle.

## Interface

Parameters:
- `LEAD`, default 2: cycles with `ss_n`=0 and `mosi`=0 before the first frame bit. This covers the slave's IDLE→CHK_CMD→WRITE/READ steps.
- `MISO_DLY`, default 1: cycles between the TAIL cycle and the first `miso` sample in a `11` frame.
- `GAP`, default 1: cycles with `ss_n`=1 after each frame.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: synchronous reset, active-high.
- `r0_valid` in 1: requester 0 has a request.
- `r0_we` in 1: 1 = write, 0 = read.
- `r0_addr` in 8: RAM address.
- `r0_wdata` in 8: write data.
- `r0_ready` out 1: request 0 accepted this cycle.
- `r1_valid`, `r1_we`, `r1_addr`, `r1_wdata`, `r1_ready`: same meanings for requester 1.
- `rsp_valid` out 1: one-cycle pulse when a transaction completes.
- `rsp_id` out 1: requester that owned the completed transaction.
- `rsp_we` out 1: type of the completed transaction.
- `rsp_rdata` out 8: read data; holds its value until the next read completes.
- `busy` out 1: high in every state except IDLE.
- `ss_n` out 1: SPI slave select, active-low.
- `mosi` out 1: SPI data to the slave.
- `miso` in 1: SPI data from the slave.

## Operation

- **States:** IDLE, LEAD, SHIFT, TAIL, WAIT, CAPT, GAP.
  - A 1-bit frame index `fidx` tracks which frame of the transaction is active.
  - A 4-bit bit counter runs the SHIFT, WAIT and CAPT states.
- **IDLE and arbitration:**
  - `rX_ready` = IDLE & `rX_valid` & grant(X). It is combinational from registered state.
  - Round-robin: when both requesters are valid, grant goes to the requester not granted last time. After reset, r0 has priority.
  - On accept, the request (`we`, `addr`, `wdata`, id) is latched, `fidx` is cleared to 0, and the state goes to LEAD.
- **Frame content:**
  - Write transaction: frame0 = {`00`, addr}, frame1 = {`01`, wdata}.
  - Read transaction: frame0 = {`10`, addr}, frame1 = {`11`, addr}. The 8 low bits of a `11` frame are don't-care to the slave; sending addr keeps them deterministic.
  - Bits are sent MSB first (bit 9 first).
- **Per-frame sequence:**
  - LEAD: `LEAD` cycles.
  - SHIFT: 10 cycles. `mosi` = frame[9−k] in SHIFT cycle k.
  - TAIL: 1 cycle, `mosi`=0.
  - Read frame1 only: WAIT for `MISO_DLY` cycles, then CAPT for 8 cycles. On each CAPT posedge, `rdata` ← {`rdata`[6:0], `miso`}, so the first sample lands in the MSB.
  - GAP: `GAP` cycles. If `fidx`=0, set `fidx`=1 and return to LEAD. Otherwise return to IDLE.
- **Completion:** `rsp_valid` pulses in the first GAP cycle of frame1. `rsp_id`/`rsp_we` update in the same cycle. `rsp_rdata` updates in that cycle only for reads.
- **Output decode:**
  - `ss_n` = 0 in LEAD, SHIFT, TAIL, WAIT and CAPT; 1 in IDLE and GAP.
  - `mosi` = 0 outside SHIFT.
- **Reset:**
  - Any in-flight transaction is dropped with no `rsp_valid`.
  - Arbitration pointer returns to r0 priority.
  - Reset mid-frame forces `ss_n`=1 in the next cycle.
- Requesters that drop `valid` before accept are never served.
- `rX_*` inputs are ignored outside IDLE.

## Timing

- **Reset values:** `ss_n`=1, `mosi`=0, `r0_ready`=`r1_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_we`=0, `rsp_rdata`=0, `busy`=0.
- All outputs except `rX_ready` are registered. State transitions occur on `clk` posedge.
- **Accept cycle** = cycle A. `ss_n` falls at A+1.
- **Write, with defaults:** 2×(2+10+1+1) = 28 cycles from A+1 until return to IDLE. `rsp_valid` at A+28.
- **Read, with defaults:** 14 + (2+10+1+1+8+1) = 37 cycles. `rsp_valid` at A+37.
- **Spacing:**
  - Inside a transaction, `ss_n` is high for `GAP` cycles between frames.
  - Between transactions, `ss_n` is high for at least `GAP`+1 cycles, because IDLE always lasts at least one cycle.
- Maximum request throughput is one accept per transaction length + 1 cycle.

## Test plan

- **Write:** r0 writes addr 0x03, data 0xB7. Required: `mosi` bits in SHIFT are 00_00000011, then 01_10110111; `ss_n` low 13 cycles per frame; `rsp_valid`, `rsp_id`=0, `rsp_we`=1 at A+28.
- **Read after write:** r0 reads addr 0x03, with the slave+RAM model preloaded by the previous write. Required: frames 10_00000011 and 11_00000011; `rsp_rdata`=0xB7 and `rsp_valid` at A+37.
- **Arbitration:** `r0_valid` and `r1_valid` both held high from reset, r0 writing 0x10←0x5A and r1 writing 0x20←0xA5. Required: r0 granted first, r1 next, then r0 again; `r1_ready` never asserts while `busy`=1.
- **Reset mid-operation:** assert `rst` during SHIFT of frame0 of a read. Required: next cycle `ss_n`=1, `mosi`=0, `busy`=0, no `rsp_valid`. A following write to 0x03 completes normally, and the slave returns to IDLE.
- **MISO capture order:** use a slave model driving `miso`=1,0,0,0,0,0,0,1 in CAPT cycles 0–7. Required: `rsp_rdata`=0x81.
- **Back-to-back:** r1 issues a write then a read with `valid` held continuously. Required: `ss_n` high for exactly 2 cycles between the two transactions; `rsp_valid` at A1+28, and the second accept at A1+29.

Source files
------------

// File: rtl/spi_ram_master.sv
// spi_ram_master
// Master-side controller for an SPI slave with a synchronous RAM behind it.
// Two requesters issue word-level read/write requests. A round-robin arbiter
// picks one. Each request then becomes two 10-bit command frames, sent MSB
// first on ss_n/mosi:
//   00 write-address, 01 write-data, 10 read-address, 11 read-data.
// During a 11 frame the 8-bit reply is shifted in from miso.
// The slave shares clk, and every SPI bit takes exactly one clk cycle.
//
// Parameters:
//   LEAD      cycles with ss_n low and mosi low before the first frame bit (1..16)
//   MISO_DLY  cycles between TAIL and the first miso sample in a 11 frame (0..16)
//   GAP       cycles with ss_n high after each frame (1..16)
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   rX_valid/we/addr/wdata/ready    request handshake for requester X (0 or 1)
//   rsp_valid/id/we/rdata           completion pulse and its attributes
//   busy                            high whenever the FSM is not idle
//   ss_n, mosi, miso                SPI lines
module spi_ram_master #(
    parameter int LEAD     = 2,
    parameter int MISO_DLY = 1,
    parameter int GAP      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r0_valid,
    input  logic       r0_we,
    input  logic [7:0] r0_addr,
    input  logic [7:0] r0_wdata,
    output logic       r0_ready,
    input  logic       r1_valid,
    input  logic       r1_we,
    input  logic [7:0] r1_addr,
    input  logic [7:0] r1_wdata,
    output logic       r1_ready,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic       rsp_we,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       ss_n,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_SHIFT, S_TAIL, S_WAIT, S_CAPT, S_GAP
    } state_t;

    localparam logic [3:0] LEAD_LAST = 4'(LEAD - 1);
    localparam logic [3:0] DLY_LAST  = 4'(MISO_DLY - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

    state_t     state_r;
    logic       fidx_r;
    logic [3:0] cnt_r;
    logic       prio_r;      // 1: requester 1 wins a tie
    logic       id_r;
    logic       we_r;
    logic [7:0] addr_r;
    logic [7:0] wdata_r;
    logic [7:0] rdata_r;
    logic       grant0_s;
    logic       grant1_s;
    logic [9:0] frame_s;

    assign grant0_s = r0_valid & (~r1_valid | ~prio_r);
    assign grant1_s = r1_valid & (~r0_valid | prio_r);
    assign r0_ready = (state_r == S_IDLE) & grant0_s;
    assign r1_ready = (state_r == S_IDLE) & grant1_s;

    // Frame being sent. The low byte of a 11 frame repeats addr, so it is never X.
    always_comb begin
        frame_s = {2'b00, addr_r};
        if (we_r) begin
            frame_s = fidx_r ? {2'b01, wdata_r} : {2'b00, addr_r};
        end else begin
            frame_s = fidx_r ? {2'b11, addr_r} : {2'b10, addr_r};
        end
    end

    // Transaction FSM. ss_n, mosi and busy are set on the edge that enters the
    // matching state, so they stay registered and aligned with state_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            fidx_r    <= 1'b0;
            cnt_r     <= 4'd0;
            prio_r    <= 1'b0;
            id_r      <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= 8'h00;
            wdata_r   <= 8'h00;
            rdata_r   <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_rdata <= 8'h00;
            busy      <= 1'b0;
            ss_n      <= 1'b1;
            mosi      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (r0_ready | r1_ready) begin
                        id_r    <= r1_ready;
                        we_r    <= r1_ready ? r1_we    : r0_we;
                        addr_r  <= r1_ready ? r1_addr  : r0_addr;
                        wdata_r <= r1_ready ? r1_wdata : r0_wdata;
                        // The loser of this grant gets priority next time.
                        prio_r  <= ~r1_ready;
                        fidx_r  <= 1'b0;
                        cnt_r   <= 4'd0;
                        state_r <= S_LEAD;
                        ss_n    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_LEAD: begin
                    if (cnt_r == LEAD_LAST) begin
                        cnt_r   <= 4'd0;
                        state_r <= S_SHIFT;
                        mosi    <= frame_s[9];
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                S_SHIFT: begin
                    if (cnt_r == 4'd9) begin
                        cnt_r   <= 4'd0;
                        state_r <= S_TAIL;
                        mosi    <= 1'b0;
                    end else begin
                        // Next cycle is shift index cnt_r+1, so it carries bit 8-cnt_r.
                        mosi  <= frame_s[4'd8 - cnt_r];
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                S_TAIL: begin
                    cnt_r <= 4'd0;
                    if (fidx_r & ~we_r) begin
                        state_r <= (MISO_DLY == 0) ? S_CAPT : S_WAIT;
                    end else begin
                        state_r <= S_GAP;
                        ss_n    <= 1'b1;
                        if (fidx_r) begin
                            rsp_valid <= 1'b1;
                            rsp_id    <= id_r;
                            rsp_we    <= we_r;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_r == DLY_LAST) begin
                        cnt_r   <= 4'd0;
                        state_r <= S_CAPT;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                S_CAPT: begin
                    rdata_r <= {rdata_r[6:0], miso};
                    if (cnt_r == 4'd7) begin
                        cnt_r     <= 4'd0;
                        state_r   <= S_GAP;
                        ss_n      <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_r;
                        rsp_we    <= we_r;
                        rsp_rdata <= {rdata_r[6:0], miso};
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        cnt_r <= 4'd0;
                        if (!fidx_r) begin
                            fidx_r  <= 1'b1;
                            state_r <= S_LEAD;
                            ss_n    <= 1'b0;
                        end else begin
                            state_r <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    cnt_r   <= 4'd0;
                    busy    <= 1'b0;
                    ss_n    <= 1'b1;
                    mosi    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_master.sv
// tb_spi_ram_master
// Directed bench for spi_ram_master. A behavioural SPI slave with a 256x8 RAM
// decodes the frames and answers reads. A table of transactions is run in a
// loop. Hand-written sequences cover arbitration, reset in the middle of a
// frame, and back-to-back requests.
module tb_spi_ram_master;

    localparam int LEAD     = 2;
    localparam int MISO_DLY = 1;
    localparam int GAP      = 1;
    localparam int CAPT0    = LEAD + 11 + MISO_DLY;  // first CAPT cycle index after ss_n falls

    logic       clk = 1'b0;
    logic       rst;
    logic       r0_valid, r0_we, r0_ready;
    logic [7:0] r0_addr, r0_wdata;
    logic       r1_valid, r1_we, r1_ready;
    logic [7:0] r1_addr, r1_wdata;
    logic       rsp_valid, rsp_id, rsp_we, busy, ss_n, mosi;
    logic [7:0] rsp_rdata;
    logic       miso = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_cnt = 0;

    spi_ram_master #(.LEAD(LEAD), .MISO_DLY(MISO_DLY), .GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ready(r1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .busy(busy), .ss_n(ss_n), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    // Cycle counter and count of completion pulses.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    // Slave model: counts ss_n-low cycles, shifts in frame bits, decodes them in TAIL.
    logic [7:0] ram [0:255];
    logic [7:0] s_addr = 8'h00;
    logic [7:0] s_rbyte = 8'h00;
    logic [9:0] s_sh = 10'h000;
    int         lo_cnt = 0;
    logic [9:0] frame_q[$];
    int         lo_q[$];

    // Slave model: shift frame bits, decode each frame, and log every ss_n-low stretch.
    always @(posedge clk) begin
        if (!ss_n) begin
            lo_cnt <= lo_cnt + 1;
            if (lo_cnt >= LEAD && lo_cnt < LEAD + 10) s_sh <= {s_sh[8:0], mosi};
            if (lo_cnt == LEAD + 10) begin
                frame_q.push_back(s_sh);
                case (s_sh[9:8])
                    2'b00, 2'b10: s_addr <= s_sh[7:0];
                    2'b01:        ram[s_addr] <= s_sh[7:0];
                    default:      s_rbyte <= ram[s_addr];
                endcase
            end
        end else begin
            if (lo_cnt != 0) lo_q.push_back(lo_cnt);
            lo_cnt <= 0;
        end
    end

    // Slave model: drive the read byte MSB first during the CAPT window.
    always @(negedge clk) begin
        miso <= (!ss_n && lo_cnt >= CAPT0 && lo_cnt < CAPT0 + 8) ?
                s_rbyte[3'(CAPT0 + 7 - lo_cnt)] : 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic v, input logic we,
                           input logic [7:0] a, input logic [7:0] d);
        if (id) begin
            r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d;
        end else begin
            r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d;
        end
    endtask

    typedef struct {
        logic       id;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [9:0] f0;
        logic [9:0] f1;
        int         lat;
        logic [7:0] rdata;
        int         lo1;
    } vec_t;

    vec_t vecs[8];

    // Issue one request, wait for the completion, then check timing, the response and the frames.
    task automatic run_vec(input vec_t v, input string tag);
        int  a;
        bit  got;
        a = 0;
        got = 1'b0;
        frame_q.delete();
        lo_q.delete();
        set_req(v.id, 1'b1, v.we, v.addr, v.wdata);
        for (int n = 0; n < 50 && !got; n++) begin
            #1;
            if (v.id ? r1_ready : r0_ready) begin
                got = 1'b1;
                a = cyc;
            end
            @(negedge clk);
        end
        set_req(v.id, 1'b0, 1'b0, 8'h00, 8'h00);
        chk({tag, "_accept"}, 32'(got), 32'd1);
        got = 1'b0;
        for (int n = 0; n < 80 && !got; n++) begin
            #1;
            if (rsp_valid) got = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(cyc - a), 32'(v.lat));
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(v.id));
        chk({tag, "_rsp_we"}, 32'(rsp_we), 32'(v.we));
        if (!v.we) chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(v.rdata));
        @(negedge clk);
        #1;
        chk({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_nframes"}, 32'(frame_q.size()), 32'd2);
        chk({tag, "_nlow"}, 32'(lo_q.size()), 32'd2);
        if (frame_q.size() >= 2) begin
            chk({tag, "_frame0"}, 32'(frame_q[0]), 32'(v.f0));
            chk({tag, "_frame1"}, 32'(frame_q[1]), 32'(v.f1));
        end
        if (lo_q.size() >= 2) begin
            chk({tag, "_low0"}, 32'(lo_q[0]), 32'd13);
            chk({tag, "_low1"}, 32'(lo_q[1]), 32'(v.lo1));
        end
    endtask

    initial begin
        int g[3];
        int ng;
        int bad;
        int a1;
        int rc;
        bit got;

        //        id    we    addr   wdata  f0       f1       lat rdata  lo1
        vecs[0] = '{1'b0, 1'b1, 8'h03, 8'hB7, 10'h003, 10'h1B7, 28, 8'h00, 13};
        vecs[1] = '{1'b0, 1'b0, 8'h03, 8'h00, 10'h203, 10'h303, 37, 8'hB7, 22};
        vecs[2] = '{1'b1, 1'b1, 8'h40, 8'h81, 10'h040, 10'h181, 28, 8'h00, 13};
        vecs[3] = '{1'b1, 1'b0, 8'h40, 8'h00, 10'h240, 10'h340, 37, 8'h81, 22};
        vecs[4] = '{1'b0, 1'b1, 8'hFF, 8'h00, 10'h0FF, 10'h100, 28, 8'h00, 13};
        vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 10'h2FF, 10'h3FF, 37, 8'h00, 22};
        vecs[6] = '{1'b0, 1'b1, 8'h03, 8'h3C, 10'h003, 10'h13C, 28, 8'h00, 13};
        vecs[7] = '{1'b0, 1'b0, 8'h03, 8'h00, 10'h203, 10'h303, 37, 8'h3C, 22};

        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ss_n", 32'(ss_n), 32'd1);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_r0_ready", 32'(r0_ready), 32'd0);
        chk("rst_r1_ready", 32'(r1_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_we", 32'(rsp_we), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Arbitration: both requesters valid from reset; expect grants r0, r1, r0.
        set_req(1'b0, 1'b1, 1'b1, 8'h10, 8'h5A);
        set_req(1'b1, 1'b1, 1'b1, 8'h20, 8'hA5);
        @(negedge clk);
        rst = 1'b0;
        ng = 0;
        bad = 0;
        g[0] = 9; g[1] = 9; g[2] = 9;
        for (int n = 0; n < 150 && ng < 3; n++) begin
            #1;
            if (r1_ready && busy) bad++;
            if (r0_ready && r1_ready) bad++;
            if (r0_ready) begin
                g[ng] = 0; ng++;
            end else if (r1_ready) begin
                g[ng] = 1; ng++;
            end
            @(negedge clk);
        end
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("arb_ngrants", 32'(ng), 32'd3);
        chk("arb_grant0", 32'(g[0]), 32'd0);
        chk("arb_grant1", 32'(g[1]), 32'd1);
        chk("arb_grant2", 32'(g[2]), 32'd0);
        chk("arb_ready_while_busy", 32'(bad), 32'd0);
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            #1;
            if (!busy) got = 1'b1;
        end
        chk("arb_done", 32'(got), 32'd1);
        chk("arb_ram10", 32'(ram[8'h10]), 32'h5A);
        chk("arb_ram20", 32'(ram[8'h20]), 32'hA5);
        @(negedge clk);

        // Table: write/read, MISO capture order (0x81), address/data extremes.
        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during SHIFT of frame0 of a read.
        rc = rsp_cnt;
        set_req(1'b0, 1'b1, 1'b0, 8'h03, 8'h00);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (r0_ready) got = 1'b1;
            @(negedge clk);
        end
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("mid_accept", 32'(got), 32'd1);
        repeat (4) @(negedge clk);
        #1;
        chk("mid_in_frame", 32'(ss_n), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_ss_n", 32'(ss_n), 32'd1);
        chk("mid_mosi", 32'(mosi), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_no_rsp", 32'(rsp_cnt), 32'(rc));
        chk("mid_slave_idle", 32'(lo_cnt), 32'd0);
        run_vec(vecs[6], "post_rst_wr");
        run_vec(vecs[7], "post_rst_rd");

        // Back-to-back: r1 write then read with valid held high throughout.
        set_req(1'b1, 1'b1, 1'b1, 8'h55, 8'h66);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (r1_ready) begin
                got = 1'b1;
                a1 = cyc;
            end
            @(negedge clk);
        end
        chk("b2b_accept1", 32'(got), 32'd1);
        r1_we = 1'b0;
        repeat (27) @(negedge clk);
        #1;
        chk("b2b_rsp1_at_28", 32'(rsp_valid), 32'd1);
        chk("b2b_rsp1_we", 32'(rsp_we), 32'd1);
        chk("b2b_ss_n_28", 32'(ss_n), 32'd1);
        @(negedge clk);
        #1;
        chk("b2b_accept2_at_29", 32'(r1_ready), 32'd1);
        chk("b2b_ss_n_29", 32'(ss_n), 32'd1);
        @(negedge clk);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        chk("b2b_ss_n_30", 32'(ss_n), 32'd0);
        repeat (36) @(negedge clk);
        #1;
        chk("b2b_rsp2_at_37", 32'(rsp_valid), 32'd1);
        chk("b2b_rsp2_we", 32'(rsp_we), 32'd0);
        chk("b2b_rdata", 32'(rsp_rdata), 32'h66);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
